// File: rtl/smi_flit_pkg.sv
// Shared constants and helpers for the SMI x8 flit width reducer.
// Used by smi_flit_reduce_x8 and smi_flit_reduce_lane_sel.
package smi_flit_pkg;

  localparam int EOFC_W   = 8;
  localparam int SCALE_X8 = 8;
  localparam int LANE_W   = 3;

  typedef enum logic {
    ST_EMPTY,
    ST_SERIALISE
  } state_e;

  // Valid byte count of a final flit, clamped to the wide flit size.
  function automatic logic [EOFC_W-1:0] sat_eofc(
    input logic [EOFC_W-1:0] eofc,
    input int                fw
  );
    int e;
    e = int'(eofc);
    if (e > fw * SCALE_X8) e = fw * SCALE_X8;
    return EOFC_W'(e);
  endfunction

  function automatic logic [LANE_W-1:0] calc_last(
    input logic [EOFC_W-1:0] eofc,
    input int                fw
  );
    int e;
    int l;
    if (eofc == '0) begin
      l = SCALE_X8 - 1;
    end else begin
      e = int'(sat_eofc(eofc, fw));
      l = (e + fw - 1) / fw - 1;
    end
    return LANE_W'(l);
  endfunction

endpackage

// File: rtl/smi_flit_reduce_lane_sel.sv
// Narrow lane mux with final-flit eofc generation.
// SMI_FLIT_REDUCE_ZERO_PAD_EN zeroes bytes past the final eofc.
module smi_flit_reduce_lane_sel
  import smi_flit_pkg::*;
#(
  parameter int FlitWidth = 4
) (
  input  logic [FlitWidth*64-1:0] hold_data,
  input  logic [LANE_W-1:0]       lane,
  input  logic [LANE_W-1:0]       last,
  input  logic [EOFC_W-1:0]       hold_eofc,
  output logic [FlitWidth*8-1:0]  lane_data,
  output logic [EOFC_W-1:0]       lane_eofc
);

  localparam int NW = FlitWidth * 8;

  always_comb begin
    lane_eofc = '0;
    if (lane == last && hold_eofc != '0)
      lane_eofc = hold_eofc - EOFC_W'(int'(last) * FlitWidth);
    lane_data = hold_data[int'(lane)*NW +: NW];
`ifdef SMI_FLIT_REDUCE_ZERO_PAD_EN
    if (lane_eofc != '0) begin
      for (int b = 0; b < FlitWidth; b++) begin
        if (b >= int'(lane_eofc)) lane_data[b*8 +: 8] = '0;
      end
    end
`endif
  end

endmodule

// File: rtl/smi_flit_reduce_x8.sv
// SMI flit reducer: one wide flit out as eight narrow flits, low bytes first.
// Optional macro SMI_FLIT_REDUCE_ZERO_PAD_EN zero-pads the final narrow flit.
module smi_flit_reduce_x8
  import smi_flit_pkg::*;
#(
  parameter int FlitWidth = 4
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    smiInReady,
  input  logic [EOFC_W-1:0]       smiInEofc,
  input  logic [FlitWidth*64-1:0] smiInData,
  output logic                    smiInStop,
  output logic                    smiOutReady,
  output logic [EOFC_W-1:0]       smiOutEofc,
  output logic [FlitWidth*8-1:0]  smiOutData,
  input  logic                    smiOutStop
);

  localparam int WW = FlitWidth * 64;
  localparam int NW = FlitWidth * 8;

  state_e              state_q, state_d;
  logic [WW-1:0]       hold_data_q, hold_data_d;
  logic [EOFC_W-1:0]   hold_eofc_q, hold_eofc_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [LANE_W-1:0]   last_q, last_d;
  logic                out_valid_q, out_valid_d;
  logic [EOFC_W-1:0]   out_eofc_q, out_eofc_d;
  logic [NW-1:0]       out_data_q, out_data_d;

  logic [NW-1:0]       lane_data;
  logic [EOFC_W-1:0]   lane_eofc;
  logic                out_load;
  logic                lane_move;
  logic                lane_done;
  logic                in_xfer;

  smi_flit_reduce_lane_sel #(
    .FlitWidth (FlitWidth)
  ) u_lane_sel (
    .hold_data (hold_data_q),
    .lane      (lane_q),
    .last      (last_q),
    .hold_eofc (hold_eofc_q),
    .lane_data (lane_data),
    .lane_eofc (lane_eofc)
  );

  always_comb begin
    out_load  = !out_valid_q || !smiOutStop;
    lane_move = (state_q == ST_SERIALISE) && out_load;
    lane_done = lane_move && (lane_q == last_q);
    // Accept a new wide flit while its predecessor's last lane leaves.
    smiInStop = srst || !((state_q == ST_EMPTY) || lane_done);
    in_xfer   = smiInReady && !smiInStop;

    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_eofc_d = hold_eofc_q;
    lane_d      = lane_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_eofc_d  = out_eofc_q;
    out_data_d  = out_data_q;

    if (out_load) begin
      out_valid_d = lane_move;
      out_eofc_d  = lane_move ? lane_eofc : '0;
      out_data_d  = lane_move ? lane_data : '0;
    end

    if (lane_move) lane_d = lane_q + LANE_W'(1);
    if (lane_done) state_d = ST_EMPTY;

    if (in_xfer) begin
      state_d     = ST_SERIALISE;
      hold_data_d = smiInData;
      hold_eofc_d = sat_eofc(smiInEofc, FlitWidth);
      last_d      = calc_last(smiInEofc, FlitWidth);
      lane_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= '0;
      hold_eofc_q <= '0;
      lane_q      <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_eofc_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_eofc_q <= hold_eofc_d;
      lane_q      <= lane_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_eofc_q  <= out_eofc_d;
      out_data_q  <= out_data_d;
    end
  end

  assign smiOutReady = out_valid_q;
  assign smiOutEofc  = out_eofc_q;
  assign smiOutData  = out_data_q;

endmodule

// File: tb/tb_smi_flit_reduce_x8.sv
// Self-checking bench for smi_flit_reduce_x8 (FlitWidth = 4).
// Directed scenarios then random traffic against a byte-level model.
module tb_smi_flit_reduce_x8;

  localparam int WW = 256;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          smiInReady = 1'b0;
  logic [7:0]    smiInEofc = '0;
  logic [WW-1:0] smiInData = '0;
  logic          smiInStop;
  logic          smiOutReady;
  logic [7:0]    smiOutEofc;
  logic [NW-1:0] smiOutData;
  logic          smiOutStop = 1'b0;

  smi_flit_reduce_x8 #(
    .FlitWidth (4)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .smiInReady  (smiInReady),
    .smiInEofc   (smiInEofc),
    .smiInData   (smiInData),
    .smiInStop   (smiInStop),
    .smiOutReady (smiOutReady),
    .smiOutEofc  (smiOutEofc),
    .smiOutData  (smiOutData),
    .smiOutStop  (smiOutStop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  e;
    logic [31:0] d;
  } nf_t;

  int            ncmp = 0;
  int            nfail = 0;
  int            cyc = 0;
  nf_t           expq[$];
  logic [WW-1:0] sq_d[$];
  logic [7:0]    sq_e[$];
  bit            pres = 0;
  int            in_rate = 100;
  int            stop_rate = 0;
  bit            force_stop = 0;
  bit            gen_random = 0;
  int            n_out = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic [31:0]   first_data = '0;
  logic [31:0]   last_data = '0;
  logic [7:0]    last_eofc = '0;
  bit            prev_stall = 0;
  logic [31:0]   pst_d = '0;
  logic [7:0]    pst_e = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] ramp(input int base);
    logic [WW-1:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = 8'(base + i);
    return r;
  endfunction

  function automatic logic [WW-1:0] rnd_wide();
    logic [WW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: split an accepted wide flit into its expected narrow flits.
  task automatic model_load(input logic [WW-1:0] d, input logic [7:0] e);
    int  ev;
    int  k;
    nf_t f;
    ev = (e == 0 || e > 32) ? 32 : int'(e);
    k  = (ev + 3) / 4;
    for (int n = 0; n < k; n++) begin
      f.d = d[n*32 +: 32];
      f.e = (e != 0 && n == k - 1) ? 8'(ev - 4 * n) : 8'd0;
`ifdef SMI_FLIT_REDUCE_ZERO_PAD_EN
      for (int b = 0; b < 4; b++)
        if (f.e != 0 && b >= int'(f.e)) f.d[b*8 +: 8] = 8'h00;
`endif
      expq.push_back(f);
    end
  endtask

  task automatic tick();
    bit            in_x;
    bit            out_x;
    bit            rst_s;
    logic [31:0]   od;
    logic [7:0]    oe;
    logic [WW-1:0] id;
    logic [7:0]    ie;
    nf_t           f;
    int            r;
    @(negedge clk);
    in_x  = smiInReady && !smiInStop;
    out_x = smiOutReady && !smiOutStop;
    rst_s = srst;
    od = smiOutData;
    oe = smiOutEofc;
    id = smiInData;
    ie = smiInEofc;
    if (prev_stall) begin
      chk("stall_data", od, pst_d);
      chk("stall_eofc", oe, pst_e);
      chk("stall_ready", smiOutReady, 1);
    end
    prev_stall = smiOutReady && smiOutStop && !rst_s;
    pst_d = od;
    pst_e = oe;
    @(posedge clk);
    #1;
    cyc++;
    if (out_x) begin
      chk("sb_nonempty", 64'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        f = expq.pop_front();
        chk("sb_data", od, f.d);
        chk("sb_eofc", oe, f.e);
      end
      n_out++;
      if (n_out == 1) begin
        first_cyc  = cyc;
        first_data = od;
      end
      last_cyc  = cyc;
      last_data = od;
      last_eofc = oe;
    end
    if (rst_s) expq.delete();
    if (in_x) begin
      model_load(id, ie);
      void'(sq_d.pop_front());
      void'(sq_e.pop_front());
      pres = 0;
    end
    if (rst_s) begin
      sq_d.delete();
      sq_e.delete();
      pres = 0;
    end
    if (gen_random && sq_d.size() == 0) begin
      sq_d.push_back(rnd_wide());
      r = int'($urandom_range(9));
      sq_e.push_back(r < 6 ? 8'd0 : 8'($urandom_range(255)));
    end
    if (!pres && sq_d.size() > 0 && int'($urandom_range(99)) < in_rate)
      pres = 1;
    smiInReady = pres;
    smiInData  = pres ? sq_d[0] : '0;
    smiInEofc  = pres ? sq_e[0] : 8'd0;
    smiOutStop = force_stop || (int'($urandom_range(99)) < stop_rate);
  endtask

  task automatic run_until(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && n_out < n; i++) tick();
    chk(tag, n_out, n);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", smiOutReady, 0);
    chk("rst_eofc", smiOutEofc, 0);
    chk("rst_data", smiOutData, 0);
    chk("rst_instop", smiInStop, 1);
    srst = 1'b0;
    #1;
    chk("rst_release_instop", smiInStop, 0);

    // 1: two back-to-back wide flits, 16 narrow flits without gaps
    n_out = 0;
    sq_d.push_back(ramp(0));
    sq_e.push_back(8'd0);
    sq_d.push_back(ramp(32));
    sq_e.push_back(8'd32);
    tick();
    tick();
    chk("t1_latency_early", smiOutReady, 0);
    tick();
    chk("t1_latency_ready", smiOutReady, 1);
    chk("t1_first_data", smiOutData, 32'h03020100);
    chk("t1_first_eofc", smiOutEofc, 0);
    run_until("t1_count", 16, 40);
    chk("t1_span", last_cyc - first_cyc, 15);
    chk("t1_last_data", last_data, 32'h3F3E3D3C);
    chk("t1_last_eofc", last_eofc, 4);
    repeat (3) tick();

    // 2: short frame of 5 bytes
    n_out = 0;
    sq_d.push_back(ramp(0));
    sq_e.push_back(8'd5);
    tick();
    tick();
    chk("t2_instop_busy", smiInStop, 1);
    tick();
    chk("t2_first_data", smiOutData, 32'h03020100);
    chk("t2_instop_last_lane", smiInStop, 0);
    run_until("t2_count", 2, 10);
`ifdef SMI_FLIT_REDUCE_ZERO_PAD_EN
    chk("t2_last_data", last_data, 32'h00000004);
`else
    chk("t2_last_data", last_data, 32'h07060504);
`endif
    chk("t2_last_eofc", last_eofc, 1);
    repeat (3) tick();

    // 3: output stall after narrow flit 2
    n_out = 0;
    sq_d.push_back(rnd_wide());
    sq_e.push_back(8'd0);
    run_until("t3_pre", 2, 20);
    force_stop = 1;
    smiOutStop = 1'b1;
    chk("t3_ready", smiOutReady, 1);
    repeat (3) tick();
    chk("t3_hold_count", n_out, 2);
    chk("t3_instop", smiInStop, 1);
    force_stop = 0;
    smiOutStop = 1'b0;
    run_until("t3_count", 8, 30);
    repeat (4) tick();
    chk("t3_exact", n_out, 8);
    chk("t3_sb_empty", expq.size(), 0);

    // 4: out-of-range eofc saturates to a full flit
    n_out = 0;
    sq_d.push_back(rnd_wide());
    sq_e.push_back(8'hFF);
    run_until("t4_count", 8, 30);
    chk("t4_last_eofc", last_eofc, 4);
    repeat (4) tick();
    chk("t4_exact", n_out, 8);

    // 5: reset mid-frame
    n_out = 0;
    sq_d.push_back(rnd_wide());
    sq_e.push_back(8'd0);
    run_until("t5_pre", 3, 20);
    srst = 1'b1;
    tick();
    chk("t5_ready", smiOutReady, 0);
    chk("t5_instop", smiInStop, 1);
    srst = 1'b0;
    tick();
    n_out = 0;
    sq_d.push_back(ramp(0));
    sq_e.push_back(8'd8);
    run_until("t5_count", 2, 20);
    repeat (4) tick();
    chk("t5_exact", n_out, 2);
    chk("t5_first_data", first_data, 32'h03020100);

    // 6: random traffic with random backpressure
    n_out = 0;
    gen_random = 1;
    in_rate = 60;
    stop_rate = 30;
    repeat (10000) tick();
    gen_random = 0;
    in_rate = 100;
    stop_rate = 0;
    for (int i = 0; i < 400 && (expq.size() != 0 || sq_d.size() != 0); i++)
      tick();
    repeat (4) tick();
    chk("t6_sb_empty", expq.size(), 0);
    chk("t6_in_drained", sq_d.size(), 0);
    chk("t6_activity", 64'(n_out > 1000), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
